// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: hex glyphs (active-high {g,f,e,d,c,b,a}),
// the blank pattern and the scan-decoder FSM states.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0 = 7'b0111111;
  localparam logic [6:0] GLYPH_1 = 7'b0000110;
  localparam logic [6:0] GLYPH_2 = 7'b1011011;
  localparam logic [6:0] GLYPH_3 = 7'b1001111;
  localparam logic [6:0] GLYPH_4 = 7'b1100110;
  localparam logic [6:0] GLYPH_5 = 7'b1101101;
  localparam logic [6:0] GLYPH_6 = 7'b1111101;
  localparam logic [6:0] GLYPH_7 = 7'b0000111;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1100111;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b1111100;
  localparam logic [6:0] GLYPH_C = 7'b1011000;
  localparam logic [6:0] GLYPH_D = 7'b1011110;
  localparam logic [6:0] GLYPH_E = 7'b1111001;
  localparam logic [6:0] GLYPH_F = 7'b1110001;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    COLLECT,
    HOLD
  } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Maps an active-high seven-segment pattern back to its hex nibble; anything
// that is not one of the sixteen glyphs (blank included) reports legal=0.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       legal
);

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b1;
    case (pattern)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed active-low seven-segment bus, captures each digit once
// its pattern has been stable long enough, and delivers the assembled word.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] word,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    overrun
);

  localparam logic [7:0] CAP_AT = 8'(STABLE_CYCLES - 1);

  scan_state_t             state;
  logic [6:0]              seg_q, seg_p;
  logic [NUM_DIGITS-1:0]   an_q, an_p;
  logic                    sel_legal, sel_legal_p, restart, capture;
  logic [7:0]              cnt;
  logic [3:0]              nibble;
  logic                    glyph_ok;
  logic [4*NUM_DIGITS-1:0] work_word, cap_word;
  logic [NUM_DIGITS-1:0]   work_err, cap_err, seen, cap_seen;

  seg7_pattern_decode u_decode (
    .pattern (~seg_q),
    .nibble  (nibble),
    .legal   (glyph_ok)
  );

  // Capture fires on the increment that brings the run length to STABLE_CYCLES;
  // a saturated counter never equals CAP_AT again, so long dwells capture once.
  always_comb begin
    sel_legal = $onehot(~an_q);
    restart   = !sel_legal_p || (an_q != an_p) || (seg_q != seg_p);
    capture   = sel_legal && !restart && (cnt == CAP_AT);
    cap_word  = work_word;
    cap_err   = work_err;
    cap_seen  = seen;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) begin
        cap_word[4*i +: 4] = nibble;
        cap_err[i]         = !glyph_ok;
        cap_seen[i]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q       <= ~SEG_BLANK;
      an_q        <= '1;
      seg_p       <= ~SEG_BLANK;
      an_p        <= '1;
      sel_legal_p <= 1'b0;
      cnt         <= 8'd0;
    end else begin
      seg_q       <= seg_n;
      an_q        <= an_n;
      seg_p       <= seg_q;
      an_p        <= an_q;
      sel_legal_p <= sel_legal;
      if (!sel_legal)
        cnt <= 8'd0;
      else if (restart)
        cnt <= 8'd1;
      else if (cnt != 8'hFF)
        cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      word       <= '0;
      digit_err  <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
      seen       <= '0;
      work_word  <= '0;
      work_err   <= '0;
    end else begin
      overrun <= 1'b0;
      case (state)
        COLLECT: begin
          if (capture) begin
            work_word <= cap_word;
            work_err  <= cap_err;
            if (&cap_seen) begin
              word       <= cap_word;
              digit_err  <= cap_err;
              word_valid <= 1'b1;
              seen       <= '0;
              state      <= HOLD;
            end else begin
              seen <= cap_seen;
            end
          end
        end
        HOLD: begin
          if (capture)
            overrun <= 1'b1;
          if (word_ready) begin
            word_valid <= 1'b0;
            state      <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed and randomized scan sequences checked cycle-by-cycle against a
// sliding-window reference model of the display decoder.
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk, rst_n;
  logic [6:0]    seg_n;
  logic [ND-1:0] an_n;
  logic [4*ND-1:0] word;
  logic [ND-1:0] digit_err;
  logic          word_valid, word_ready, overrun;

  int n_checks, n_fail;
  int valid_cycles, ovr_cnt;
  int capcnt [ND];
  logic prev_v;
  logic [15:0] latched_word;
  logic [3:0]  latched_err;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h67, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};

  // Reference model state
  logic [10:0] hist [$];
  logic [3:0]  m_part [ND];
  logic [ND-1:0] m_perr, m_seen, m_err;
  logic [15:0] m_word;
  logic        m_valid, m_overrun;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .word       (word),
    .digit_err  (digit_err),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] dsel(input int d);
    return ~(4'b0001 << d);
  endfunction

  function automatic logic [6:0] pat(input int n);
    return ~glyph[n];
  endfunction

  function automatic int zeroCount(input logic [3:0] an);
    int z = 0;
    for (int i = 0; i < ND; i++) if (!an[i]) z++;
    return z;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    hist.delete();
    for (int j = 0; j <= SC; j++) hist.push_back({4'hF, 7'h7F});
    for (int i = 0; i < ND; i++) m_part[i] = 4'h0;
    m_perr = '0; m_seen = '0; m_err = '0; m_word = '0;
    m_valid = 1'b0; m_overrun = 1'b0;
  endtask

  // A digit is captured when the previous SC registered samples form one legal
  // run that started exactly SC samples ago.
  task automatic modelEdge(input logic [10:0] cur, input logic rdy);
    logic [10:0] h1;
    logic cap, er;
    logic [3:0] nib;
    int d, n;
    n  = hist.size();
    h1 = hist[n-1];
    cap = (zeroCount(h1[10:7]) == 1);
    for (int j = 1; j <= SC; j++) if (hist[n-j] != h1) cap = 1'b0;
    if (hist[n-SC-1] == h1) cap = 1'b0;
    m_overrun = 1'b0;
    if (m_valid) begin
      if (cap) m_overrun = 1'b1;
      if (rdy) m_valid = 1'b0;
    end else if (cap) begin
      d = 0;
      for (int i = 0; i < ND; i++) if (!h1[7+i]) d = i;
      nib = 4'h0; er = 1'b1;
      for (int g = 0; g < 16; g++) if (glyph[g] == ~h1[6:0]) begin nib = 4'(g); er = 1'b0; end
      m_part[d] = nib; m_perr[d] = er; m_seen[d] = 1'b1;
      if (&m_seen) begin
        for (int i = 0; i < ND; i++) m_word[4*i +: 4] = m_part[i];
        m_err = m_perr; m_valid = 1'b1; m_seen = '0;
      end
    end
    hist.push_back(cur);
    if (hist.size() > SC + 1) void'(hist.pop_front());
  endtask

  task automatic tick();
    logic [10:0] cur;
    logic rdy;
    cur = {an_n, seg_n};
    rdy = word_ready;
    @(posedge clk);
    if (rst_n) modelEdge(cur, rdy);
    #1;
    checkOutput("cycle", 32'({word, digit_err, word_valid, overrun}),
                32'({m_word, m_err, m_valid, m_overrun}));
    if (word_valid) valid_cycles++;
    if (overrun) ovr_cnt++;
    if (word_valid && !prev_v) begin latched_word = word; latched_err = digit_err; end
    prev_v = word_valid;
    for (int i = 0; i < ND; i++) if (dut.capture && !dut.an_q[i]) capcnt[i]++;
  endtask

  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int cycles);
    an_n = an;
    seg_n = seg;
    repeat (cycles) tick();
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_async", 32'({word, digit_err, word_valid, overrun}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_v = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; valid_cycles = 0; ovr_cnt = 0; prev_v = 1'b0;
    latched_word = '0; latched_err = '0;
    for (int i = 0; i < ND; i++) capcnt[i] = 0;
    rst_n = 1'b0; seg_n = 7'h7F; an_n = 4'hF; word_ready = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("reset_outputs", 32'({word, digit_err, word_valid, overrun}), 32'd0);
    checkOutput("reset_cnt", 32'(dut.cnt), 32'd0);

    $display("[TB] basic word 3 A d 7");
    word_ready = 1'b1;
    valid_cycles = 0;
    applyStimulus(dsel(0), pat(3), 6);
    applyStimulus(dsel(1), pat(10), 6);
    applyStimulus(dsel(2), pat(13), 6);
    applyStimulus(dsel(3), pat(7), 6);
    checkOutput("first_word", 32'(latched_word), 32'h7dA3);
    checkOutput("first_err", 32'(latched_err), 32'h0);
    checkOutput("valid_one_cycle", 32'(valid_cycles), 32'd1);

    $display("[TB] glitch rejection and illegal glyphs");
    for (int i = 0; i < ND; i++) capcnt[i] = 0;
    applyStimulus(dsel(0), 7'h7F, 6);
    applyStimulus(dsel(1), pat(8), 3);
    applyStimulus(dsel(1), pat(2), 6);
    applyStimulus(dsel(2), ~7'b0100100, 6);
    applyStimulus(dsel(3), pat(1), 6);
    checkOutput("glitch_word", 32'(latched_word), 32'h1020);
    checkOutput("illegal_err", 32'(latched_err), 32'h5);
    checkOutput("digit1_captures", 32'(capcnt[1]), 32'd1);

    $display("[TB] backpressure with illegal select");
    word_ready = 1'b0;
    ovr_cnt = 0;
    applyStimulus(dsel(0), pat(9), 6);
    applyStimulus(dsel(1), pat(8), 6);
    applyStimulus(dsel(2), pat(7), 6);
    applyStimulus(dsel(3), pat(6), 6);
    checkOutput("bp_word", 32'(latched_word), 32'h6789);
    applyStimulus(dsel(0), pat(14), 6);
    applyStimulus(4'b0011, pat(5), 5);
    checkOutput("illegal_sel_cnt", 32'(dut.cnt), 32'd0);
    applyStimulus(dsel(1), pat(12), 5);
    checkOutput("held_word", 32'(word), 32'h6789);
    checkOutput("held_valid", 32'(word_valid), 32'd1);
    checkOutput("overrun_count", 32'(ovr_cnt), 32'd2);
    word_ready = 1'b1;
    applyStimulus(dsel(0), pat(10), 6);
    applyStimulus(dsel(1), pat(11), 6);
    applyStimulus(dsel(2), pat(12), 6);
    applyStimulus(dsel(3), pat(13), 6);
    checkOutput("after_bp_word", 32'(latched_word), 32'hdcbA);

    $display("[TB] reset mid-collection");
    applyStimulus(dsel(0), pat(1), 6);
    applyStimulus(dsel(1), pat(2), 6);
    applyReset();
    valid_cycles = 0;
    applyStimulus(dsel(2), pat(3), 6);
    applyStimulus(dsel(3), pat(4), 6);
    checkOutput("no_word_after_reset", 32'(valid_cycles), 32'd0);
    applyStimulus(dsel(0), pat(5), 6);
    applyStimulus(dsel(1), pat(6), 6);
    checkOutput("reset_next_word", 32'(latched_word), 32'h4365);

    $display("[TB] long dwell");
    for (int i = 0; i < ND; i++) capcnt[i] = 0;
    applyStimulus(dsel(0), pat(9), 300);
    checkOutput("long_dwell_captures", 32'(capcnt[0]), 32'd1);
    checkOutput("cnt_saturated", 32'(dut.cnt), 32'd255);

    $display("[TB] randomized scanning");
    for (int k = 0; k < 250; k++) begin
      logic [3:0] an;
      logic [6:0] seg;
      if ($urandom_range(0, 9) == 0) an = 4'($urandom_range(0, 15));
      else an = dsel($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) seg = 7'($urandom);
      else seg = pat($urandom_range(0, 15));
      word_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(an, seg, $urandom_range(1, 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the hex-to-seven-segment encoder. Samples a multiplexed, active-low seven-segment display bus, consisting of segment lines plus per-digit anode enables. It waits for each digit's pattern to be stable, decodes the pattern back to a hex nibble, and assembles one nibble per digit into a word. The word is delivered over a valid/ready handshake. Sits between display-bus pins, or the display-driver output in loopback, and self-test or monitoring logic.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..8)
- STABLE_CYCLES, 4, consecutive identical samples required before capture (2..255)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- seg_n  in  7  segment lines, active-low, bit order {g,f,e,d,c,b,a}
- an_n  in  NUM_DIGITS  digit enables, active-low; bit i selects digit i
- word  out  4*NUM_DIGITS  digit i nibble at word[4i+3:4i]
- digit_err  out  NUM_DIGITS  bit i set: digit i pattern was not a legal hex glyph
- word_valid  out  1  word/digit_err valid
- word_ready  in  1  consumer accepts when word_valid && word_ready
- overrun  out  1  one-cycle pulse: capture discarded while in HOLD

## Operation
- Inputs registered once: seg_q, an_q. All logic uses the registered copies.
- Legal glyphs, active-high {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1100111, A=1110111, b=1111100
  - c=1011000, d=1011110, E=1111001, F=1110001
- Any other pattern, including blank, decodes to nibble 0 with the error bit set.
- Select legality: an_q is legal only if exactly one bit is low. An illegal select (none or several low) clears the stability counter, and no capture occurs.
- Stability counter, 8-bit saturating:
  - Set to 1 when the legal (an_q, seg_q) pair differs from the previous cycle's pair, or when the previous cycle's select was illegal.
  - Otherwise increments.
- Capture fires exactly once per dwell, on the cycle the counter reaches STABLE_CYCLES. Capture writes the nibble and error bit for the selected digit and sets that digit's seen bit. Re-capturing a digit before the word completes overwrites its nibble.
- FSM states:
  - COLLECT: captures accepted. When a capture makes all seen bits 1, the completed word/digit_err are latched to the outputs, word_valid asserts, seen clears, and the FSM moves to HOLD.
  - HOLD: word, digit_err and word_valid are held stable. Any capture is discarded and pulses overrun. The stability counter keeps running. On word_valid && word_ready, the FSM deasserts word_valid and returns to COLLECT.
- Reset values: state=COLLECT, word=0, digit_err=0, word_valid=0, overrun=0, seen=0, counter=0, seg_q=7'h7F, an_q=all ones.

## Timing
- Input pair first present before edge k is registered at edge k and sets the counter to 1 at edge k+1. Capture occurs at edge k+STABLE_CYCLES.
- word_valid rises on the same edge as the completing capture, with no extra cycle.
- Handshake:
  - The transfer edge drops word_valid.
  - A capture on the transfer edge itself is discarded with overrun.
  - The first capture accepted into the next word occurs on a later edge.
- word_ready is ignored while word_valid=0.
- rst_n assertion mid-word or mid-HOLD immediately and asynchronously forces the reset values; the partial word is lost.
- Counter saturates at 255; no wrap-around, so no re-capture on a long dwell.

## Structure
- Package seg7_pkg holds:
  - the 16 glyph constants;
  - the FSM state typedef {COLLECT, HOLD};
  - the blank-pattern constant.
- The encoder uses the same glyph constants, so d and b are distinct.
- Sub-module seg7_pattern_decode: combinational, 7-bit active-high pattern in, nibble plus legal flag out; one instance.

## Test plan
- NUM_DIGITS=4, STABLE_CYCLES=4.
  - Stimulus: digits 0..3 scanned as 3, A, d, 7 (seg_n = ~pattern), 6 cycles each, word_ready=1.
  - Required: word=16'h7dA3, digit_err=0, word_valid high exactly one cycle, on the edge digit 3 captures.
- Glitch rejection: digit 1 shows 8 for 3 cycles and then 2 for 6 cycles. Required: nibble 1 = 2, and exactly one capture for digit 1.
- Illegal patterns:
  - Digit 2 shows 0100100; digit 0 shows blank.
  - Required: digit_err=4'b0101, with the corresponding nibbles 0.
- Backpressure and illegal select:
  - Stimulus: word_ready=0 for 40 cycles while scanning continues; an_n=4'b0011 injected for 5 cycles.
  - Required: word held constant and overrun pulses once per discarded capture. No capture and no counter advance during an_n=0011. After word_ready=1, the next word completes correctly.
- Reset mid-collection: rst_n low for 1 cycle after 2 digits are captured. Required: all outputs 0 immediately, and the next word needs all 4 digits again.
- Long dwell: digit 0 held for 300 cycles. Required: a single capture, with the counter saturated at 255.
